// File: rtl/sr_bank_ctrl.sv
// Round-robin set/clear controller for a shared bank of SR flip-flops with Q-feedback verify.
// Optional toggle opcode (OP=11) is enabled by defining SR_TOGGLE_EN.
module sr_bank_ctrl #(
  parameter int unsigned N         = 8,
  parameter int unsigned IW        = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned PULSE_CYC = 1,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_a,
  input  logic [1:0]    i_op_a,
  input  logic [IW-1:0] i_idx_a,
  output logic          o_ack_a,
  input  logic          i_req_b,
  input  logic [1:0]    i_op_b,
  input  logic [IW-1:0] i_idx_b,
  output logic          o_ack_b,
  input  logic [N-1:0]  i_q_fb,
  output logic [N-1:0]  o_s,
  output logic [N-1:0]  o_r,
  output logic          o_busy,
  output logic          o_gnt_id,
  output logic          o_err
);

  localparam int unsigned CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CntLast = CW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] TmrLast = TW'(TIMEOUT - 1);
`ifdef SR_TOGGLE_EN
  localparam bit ToggleEn = 1'b1;
`else
  localparam bit ToggleEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StDrive, StCheck, StAck} state_e;

  state_e        r_state, w_state_nxt;
  logic          r_ptr, w_ptr_nxt;
  logic          r_gnt, w_gnt_nxt;
  logic [N-1:0]  r_sel, w_sel_nxt;
  logic          r_exp, w_exp_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_ack_a, w_ack_a_nxt;
  logic          r_ack_b, w_ack_b_nxt;
  logic          r_err, w_err_nxt;
  logic [N-1:0]  r_s, w_s_nxt;
  logic [N-1:0]  r_r, w_r_nxt;

  logic          w_any;
  logic          w_win;
  logic [1:0]    w_op;
  logic [IW-1:0] w_idx;
  logic [N-1:0]  w_sel;
  logic          w_qsel;
  logic          w_chk;

  assign w_any  = i_req_a | i_req_b;
  assign w_win  = (i_req_a & i_req_b) ? r_ptr : i_req_b;
  assign w_op   = w_win ? i_op_b : i_op_a;
  assign w_idx  = w_win ? i_idx_b : i_idx_a;
  // One-hot target; shifting past the top leaves it all-zero, which flags IDX>=N.
  assign w_sel  = N'(1) << w_idx;
  assign w_qsel = |(i_q_fb & w_sel);
  assign w_chk  = |(i_q_fb & r_sel);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_exp_nxt   = r_exp;
    w_cnt_nxt   = r_cnt;
    w_tmr_nxt   = r_tmr;
    w_busy_nxt  = r_busy;
    w_ack_a_nxt = 1'b0;
    w_ack_b_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_s_nxt     = r_s;
    w_r_nxt     = r_r;

    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_ptr_nxt  = ~w_win;
          w_gnt_nxt  = w_win;
          w_busy_nxt = 1'b1;
          w_sel_nxt  = w_sel;
          w_cnt_nxt  = '0;
          w_tmr_nxt  = '0;
          w_s_nxt    = '0;
          w_r_nxt    = '0;
          if ((w_sel == '0) || (w_op == 2'b00) || ((w_op == 2'b11) && !ToggleEn)) begin
            w_state_nxt = StAck;
            w_ack_a_nxt = ~w_win;
            w_ack_b_nxt = w_win;
            w_err_nxt   = (w_sel == '0) || (w_op != 2'b00);
          end else begin
            w_state_nxt = StDrive;
            case (w_op)
              2'b01: begin
                w_s_nxt   = w_sel;
                w_exp_nxt = 1'b1;
              end
              2'b10: begin
                w_r_nxt   = w_sel;
                w_exp_nxt = 1'b0;
              end
              default: begin
                if (w_qsel) w_r_nxt = w_sel;
                else        w_s_nxt = w_sel;
                w_exp_nxt = ~w_qsel;
              end
            endcase
          end
        end
      end
      StDrive: begin
        if (r_cnt == CntLast) begin
          w_state_nxt = StCheck;
          w_s_nxt     = '0;
          w_r_nxt     = '0;
          w_tmr_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StCheck: begin
        if (w_chk == r_exp) begin
          w_state_nxt = StAck;
          w_ack_a_nxt = ~r_gnt;
          w_ack_b_nxt = r_gnt;
        end else if (r_tmr == TmrLast) begin
          w_state_nxt = StAck;
          w_ack_a_nxt = ~r_gnt;
          w_ack_b_nxt = r_gnt;
          w_err_nxt   = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      StAck: begin
        w_state_nxt = StIdle;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = StIdle;
        w_busy_nxt  = 1'b0;
        w_s_nxt     = '0;
        w_r_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_ptr   <= 1'b0;
      r_gnt   <= 1'b0;
      r_sel   <= '0;
      r_exp   <= 1'b0;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_busy  <= 1'b0;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_err   <= 1'b0;
      r_s     <= '0;
      r_r     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_exp   <= w_exp_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmr   <= w_tmr_nxt;
      r_busy  <= w_busy_nxt;
      r_ack_a <= w_ack_a_nxt;
      r_ack_b <= w_ack_b_nxt;
      r_err   <= w_err_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
    end
  end

  assign o_s      = r_s;
  assign o_r      = r_r;
  assign o_ack_a  = r_ack_a;
  assign o_ack_b  = r_ack_b;
  assign o_busy   = r_busy;
  assign o_gnt_id = r_gnt;
  assign o_err    = r_err;

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Directed bench for sr_bank_ctrl: u_dut0 (PULSE_CYC=1) for most cases, u_dut1 (PULSE_CYC=4)
// for the reset-mid-DRIVE case. Toggle expectations follow SR_TOGGLE_EN.
module tb_sr_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b, req1;
  logic [1:0] op_a, op_b;
  logic [3:0] idx_a, idx_b;
  logic [7:0] q0, q1, ldv0;
  logic       ld0, ld1, stuck0;

  logic [7:0] s0, r0, s1, r1;
  logic       ack_a0, ack_b0, busy0, gnt0, err0;
  logic       ack_a1, ack_b1, busy1, gnt1, err1;

  int n_checks = 0;
  int n_fail   = 0;
  int ovl      = 0;
  int multi    = 0;
  int act0     = 0;
  int ract0    = 0;
  int ack1cnt  = 0;

  always #5 clk = ~clk;

  sr_bank_ctrl #(.N(8), .IW(4), .PULSE_CYC(1), .TIMEOUT(4)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_a(req_a), .i_op_a(op_a), .i_idx_a(idx_a), .o_ack_a(ack_a0),
    .i_req_b(req_b), .i_op_b(op_b), .i_idx_b(idx_b), .o_ack_b(ack_b0),
    .i_q_fb(q0), .o_s(s0), .o_r(r0), .o_busy(busy0), .o_gnt_id(gnt0), .o_err(err0)
  );

  sr_bank_ctrl #(.N(8), .IW(4), .PULSE_CYC(4), .TIMEOUT(4)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_a(req1), .i_op_a(op_a), .i_idx_a(idx_a), .o_ack_a(ack_a1),
    .i_req_b(1'b0), .i_op_b(2'b00), .i_idx_b(4'd0), .o_ack_b(ack_b1),
    .i_q_fb(q1), .o_s(s1), .o_r(r1), .o_busy(busy1), .o_gnt_id(gnt1), .o_err(err1)
  );

  // Behavioural SR banks
  always @(posedge clk) begin
    if (ld0)         q0 <= ldv0;
    else if (stuck0) q0 <= '0;
    else             q0 <= (q0 & ~r0) | s0;
    if (ld1) q1 <= '0;
    else     q1 <= (q1 & ~r1) | s1;
  end

  always @(negedge clk) begin
    if (((s0 & r0) != 0) || ((s1 & r1) != 0)) ovl++;
    if (($countones(s0 | r0) > 1) || ($countones(s1 | r1) > 1)) multi++;
    if ((s0 | r0) != 0) act0++;
    if (r0 != 0) ract0++;
    if (ack_a1 | ack_b1) ack1cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits on negedges for an ACK from u_dut0 (sel=0) or u_dut1 (sel=1); n = negedges consumed.
  task automatic wait_ack(input bit sel, input int max, output int n, output logic who_b,
                          output logic e);
    n = 0; who_b = 1'b0; e = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      n++;
      if (sel ? ack_a1 : (ack_a0 | ack_b0)) begin
        who_b = sel ? 1'b0 : ack_b0;
        e     = sel ? err1 : err0;
        return;
      end
    end
    check_val("ack_timeout", n, 0);
  endtask

  int   n;
  logic wb, e;
  int   snap, snap_r;

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; req1 = 1'b0;
    op_a = 2'b00; op_b = 2'b00; idx_a = '0; idx_b = '0;
    ld0 = 1'b1; ld1 = 1'b1; ldv0 = '0; stuck0 = 1'b0;

    // Reset state
    @(negedge clk);
    check_val("rst_outs0", {s0, r0, ack_a0, ack_b0, busy0, err0, gnt0}, 0);
    check_val("rst_outs1", {s1, r1, ack_a1, busy1, err1, gnt1}, 0);
    ld0 = 1'b0; ld1 = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // Single set of bit 3 from A
    snap_r = ract0;
    req_a = 1'b1; op_a = 2'b01; idx_a = 4'd3;
    @(negedge clk);
    check_val("t1_s", s0, 8'h08);
    check_val("t1_busy_gnt", {busy0, gnt0}, 2'b10);
    wait_ack(1'b0, 10, n, wb, e);
    check_val("t1_lat", n + 1, 3);
    check_val("t1_who_err", {wb, e}, 2'b00);
    req_a = 1'b0;
    check_val("t1_q", q0, 8'h08);
    @(negedge clk);
    check_val("t1_idle", {ack_a0, busy0}, 2'b00);
    check_val("t1_r_quiet", ract0 - snap_r, 0);

    // Simultaneous requests after reset: A first, then B wins while A is still held
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    req_a = 1'b1; op_a = 2'b10; idx_a = 4'd3;
    req_b = 1'b1; op_b = 2'b01; idx_b = 4'd5;
    @(negedge clk);
    check_val("t2_gnt_first", gnt0, 0);
    wait_ack(1'b0, 10, n, wb, e);
    check_val("t2_ack1", {wb, e}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    check_val("t2_gnt_second", gnt0, 1);
    wait_ack(1'b0, 10, n, wb, e);
    check_val("t2_ack2", {wb, e}, 2'b10);
    req_b = 1'b0;
    wait_ack(1'b0, 10, n, wb, e);
    check_val("t2_ack3", {wb, e}, 2'b00);
    req_a = 1'b0;
    check_val("t2_q", q0, 8'h20);
    @(negedge clk);

    // Stuck bank: set never observed, timeout after 4 CHECK cycles
    ld0 = 1'b1; ldv0 = 8'h00; stuck0 = 1'b1;
    @(negedge clk);
    ld0 = 1'b0;
    req_a = 1'b1; op_a = 2'b01; idx_a = 4'd2;
    wait_ack(1'b0, 12, n, wb, e);
    check_val("t3_lat", n, 6);
    check_val("t3_who_err", {wb, e}, 2'b01);
    req_a = 1'b0; stuck0 = 1'b0;
    @(negedge clk);

    // Out-of-range index from B, then a no-op from A
    snap = act0;
    req_b = 1'b1; op_b = 2'b01; idx_b = 4'd9;
    wait_ack(1'b0, 6, n, wb, e);
    check_val("t4_idx_lat", n, 1);
    check_val("t4_idx_who_err", {wb, e}, 2'b11);
    req_b = 1'b0;
    @(negedge clk);
    req_a = 1'b1; op_a = 2'b00; idx_a = 4'd1;
    wait_ack(1'b0, 6, n, wb, e);
    check_val("t4_nop_lat", n, 1);
    check_val("t4_nop_who_err", {wb, e}, 2'b00);
    req_a = 1'b0;
    @(negedge clk);
    check_val("t4_no_sr", act0 - snap, 0);

    // Reset during the 2nd DRIVE cycle of u_dut1
    snap = ack1cnt;
    op_a = 2'b01; idx_a = 4'd6; req1 = 1'b1;
    @(negedge clk);
    check_val("t5_s_drive", s1, 8'h40);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("t5_s_async", s1, 8'h00);
    check_val("t5_busy_gnt_ack", {busy1, gnt1, ack_a1}, 3'b000);
    req1 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("t5_no_ack", ack1cnt - snap, 0);
    req1 = 1'b1;
    wait_ack(1'b1, 12, n, wb, e);
    check_val("t5_relat", n, 6);
    check_val("t5_err", e, 0);
    req1 = 1'b0;
    @(negedge clk);

    // Toggle bit 0 with Q_FB=8'h01
    ld0 = 1'b1; ldv0 = 8'h01;
    @(negedge clk);
    ld0 = 1'b0;
    snap = act0;
    req_a = 1'b1; op_a = 2'b11; idx_a = 4'd0;
`ifdef SR_TOGGLE_EN
    @(negedge clk);
    check_val("t6_sr", {s0, r0}, 16'h0001);
    wait_ack(1'b0, 10, n, wb, e);
    check_val("t6_lat", n + 1, 3);
    check_val("t6_who_err", {wb, e}, 2'b00);
    req_a = 1'b0;
    check_val("t6_q", q0, 8'h00);
`else
    wait_ack(1'b0, 6, n, wb, e);
    check_val("t6_lat", n, 1);
    check_val("t6_who_err", {wb, e}, 2'b01);
    req_a = 1'b0;
    @(negedge clk);
    check_val("t6_no_sr", act0 - snap, 0);
`endif
    @(negedge clk);

    check_val("sr_overlap", ovl, 0);
    check_val("sr_multihot", multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_bank_ctrl.md
Name: sr_bank_ctrl

Overview:
- Controller that shares one bank of N SR flip-flops between two requesters, A and B.
- Arbitrates set/clear commands round-robin and drives one-hot S/R pulses into the bank.
- Verifies the result on the bank's Q feedback, then completes a req/ack handshake.
- Guarantees the forbidden S=R=1 condition never reaches any bank bit.

Parameters:
- N, 8, number of SR flip-flop bits in the bank.
- IW, $clog2(N) (min 1), width of bit-index ports.
- PULSE_CYC, 1, number of cycles S or R is held high per command (>=1).
- TIMEOUT, 4, number of CHECK cycles allowed before failure is declared (>=1).

Ports:
- CLK  in  1  single system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_A  in  1  requester A command request, level, held until ACK_A.
- OP_A  in  2  A opcode: 00 no-op, 01 set, 10 clear, 11 toggle.
- IDX_A  in  IW  A target bit index.
- ACK_A  out  1  one-cycle completion pulse to A.
- REQ_B  in  1  requester B command request, same rules as A.
- OP_B  in  2  B opcode, same encoding as OP_A.
- IDX_B  in  IW  B target bit index.
- ACK_B  out  1  one-cycle completion pulse to B.
- Q_FB  in  N  Q outputs of the SR bank.
- S  out  N  set inputs to the bank.
- R  out  N  reset inputs to the bank.
- BUSY  out  1  high while a command is in flight (any state except IDLE).
- GNT_ID  out  1  requester currently served: 0=A, 1=B.
- ERR  out  1  valid only with ACK_x; 1 = command failed.

Behaviour:
- Reset (RST_N=0, async):
  - S=0, R=0, ACK_A=0, ACK_B=0, BUSY=0, ERR=0, GNT_ID=0.
  - Round-robin pointer favours A; timer and pulse counter cleared; state IDLE.
  - Asserting reset mid-command drops S/R immediately. No ACK is issued for the aborted command.
- FSM states: IDLE, DRIVE, CHECK, ACK. All registered outputs.
- IDLE:
  - On a rising edge with any REQ high, latch the winner's OP and IDX. Only one requester wins.
  - If both REQs are high, the winner is the round-robin pointer's choice. After every grant the pointer moves to the non-winner.
  - GNT_ID is set to the winner. BUSY=1 from the next cycle.
  - Next state:
    - IDX>=N → ACK with ERR=1.
    - OP=00 → ACK with ERR=0.
    - OP=11 with SR_TOGGLE_EN undefined → ACK with ERR=1.
    - Otherwise → DRIVE.
- DRIVE:
  - Set: S[idx]=1. Clear: R[idx]=1. All other bits of S and R are 0.
  - Held for exactly PULSE_CYC cycles, then → CHECK.
  - Invariant: (S & R)==0 in every cycle, and at most one bit of S|R is high.
- CHECK:
  - S=R=0. Compare Q_FB[idx] to the expected value (1 for set, 0 for clear).
  - Match → ACK with ERR=0.
  - No match → timer increments. After TIMEOUT non-matching CHECK cycles → ACK with ERR=1.
- ACK:
  - ACK_<GNT_ID>=1 and ERR valid for exactly one cycle. Then → IDLE with BUSY=0.
- Handshake and sampling rules:
  - OP/IDX are sampled only at grant; changes after grant are ignored.
  - A requester must drop REQ in the cycle after its ACK. A REQ still high in IDLE is a new request.
  - A REQ withdrawn before ACK is not an abort: the command completes and ACK is still pulsed.
- Latency (PULSE_CYC=1, bank responding on the edge ending DRIVE):
  - Grant edge E → DRIVE in cycle E+1 → CHECK match in E+2 → ACK high in E+3.
  - General formula: ACK at E + PULSE_CYC + 1 + (CHECK cycles to match).
- Q_FB is treated as synchronous to CLK; no synchronizer.

Optional Feature:
- Macro: SR_TOGGLE_EN.
- Defined: OP=11 (toggle) is supported.
  - Expected value = ~Q_FB[idx], sampled at grant.
  - DRIVE asserts R[idx] if the sampled Q_FB[idx]=1, else S[idx].
  - CHECK and ACK proceed as for set/clear.
- Undefined: OP=11 is rejected. No S/R activity; ACK with ERR=1 in the cycle after the grant edge.

Test Plan:
- Reset then single set: REQ_A=1, OP_A=01, IDX_A=3, bank model follows S/R.
  - S=8'h08 for 1 cycle, then ACK_A=1 with ERR=0 3 cycles after grant.
  - Q_FB=8'h08; R never nonzero.
- Simultaneous requests: REQ_A/REQ_B both high, B sets bit 5, A clears bit 3.
  - First grant GNT_ID=0 (A), second GNT_ID=1 (B).
  - Repeat with both requests still held: B is served first.
  - (S&R)==0 in every cycle.
- Stuck bank: Q_FB forced to 0, set bit 2, TIMEOUT=4.
  - Exactly 4 CHECK cycles, then ACK_A with ERR=1.
- Invalid commands:
  - IDX_B=9 with N=8 → ACK_B with ERR=1, S=R=0 throughout.
  - OP=00 → ACK with ERR=0, no S/R pulse.
- Reset mid-DRIVE: PULSE_CYC=4, deassert RST_N in the 2nd DRIVE cycle.
  - S drops to 0 asynchronously; no ACK; BUSY=0, GNT_ID=0.
  - After reset release, the next request is granted normally.
- Toggle: Q_FB=8'h01, OP_A=11, IDX_A=0.
  - With SR_TOGGLE_EN: R=8'h01 pulse, ACK_A with ERR=0, Q_FB=8'h00.
  - Without SR_TOGGLE_EN: no pulse, ACK_A with ERR=1.
